spi_gain_bridge: RTL
====================

Name: spi_gain_bridge

Overview:
- SPI-slave host interface that turns serial frames from the external controller into single-cycle register writes toward the equalizer gain register map, using the we/addr/data_in write protocol.
- Keeps a shadow copy of every band gain code so the host can read codes back over MISO.
- Sits between the board SPI pins and the gain register map, in the single system clock domain.

Parameters:
- NUM_BANDS, 10, number of valid band addresses (0..NUM_BANDS-1).
- CODE_WIDTH, 8, width of the gain code carried in a frame and written to the map.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sclk  input  1  SPI clock, mode 0, asynchronous to clk
- cs_n  input  1  SPI chip select, active-low
- mosi  input  1  SPI data in
- miso  output  1  SPI data out
- miso_oe  output  1  MISO output enable; high while a read frame is selected
- we  output  1  one-clk write strobe to the register map
- addr  output  8  register address; valid while we=1
- wr_data  output  CODE_WIDTH  gain code; valid while we=1
- busy  output  1  high from frame start until the frame ends or aborts
- frame_err  output  1  one-clk pulse on an aborted or short frame

Behaviour:
- Reset: clk and rst only; rst asynchronous, active-high.
- Reset values: all outputs 0; shadow array cleared to 0; state WAIT_IDLE.
- Synchronizers: sclk, cs_n and mosi each pass through a 2-FF synchronizer. Edge detection runs on the synchronized sclk. Required timing: sclk <= clk/8.
- Frame: 16 bits, MSB first. bit15 = R/W (0 write, 1 read); bits14:8 = 7-bit address, zero-extended onto addr; bits7:0 = code.
- State WAIT_IDLE: stay until synced cs_n=1, then go to IDLE. This covers reset released mid-frame.
- State IDLE: synced cs_n falling -> SHIFT; bit_cnt=0; busy=1.
- State SHIFT:
  - Each synced sclk rise shifts mosi into a 16-bit shift register and increments bit_cnt.
  - At bit_cnt=8 with R/W=1: load a 8-bit tx register with shadow[addr], or 0x00 if addr >= NUM_BANDS; set miso_oe=1.
  - Each synced sclk fall while miso_oe=1 drives miso = tx MSB, then shifts tx left.
  - At bit_cnt=16: go to COMMIT.
- State COMMIT (1 clk):
  - Write with addr < NUM_BANDS: we=1, addr, wr_data = received code; shadow[addr] updated the same edge.
  - Write with addr >= NUM_BANDS: no we and no shadow change; no error.
  - Read: no we.
  - Then go to DRAIN.
- State DRAIN: ignore further sclk edges (extra bits are discarded); wait for cs_n high -> IDLE; busy=0; miso_oe=0; miso=0.
- Abort: cs_n rises in SHIFT before 16 bits -> frame_err pulse for 1 clk, no write, go to IDLE.
- Latency: we asserts in the clk cycle after the 16th synced rising edge is detected, which is <= 4 clk after the pad sclk edge.
- we is never asserted for more than one clk per frame.
- Back-to-back frames: cs_n high for at least 4 clk between frames is required. A shorter gap is undefined but must not produce a write with a corrupted address.
- rst during any state: immediate return to reset values; a partial frame never produces we.

Optional Feature:
- Macro SPI_SHADOW_READBACK_EN.
- Defined: shadow array present; reads return the stored codes as above.
- Undefined: no shadow storage; read frames shift out 0x00, miso_oe still follows the read protocol, and writes behave unchanged.

Test Plan:
- Write frame 0x0011 (addr 0, code 0x11) -> exactly one we pulse with addr=0x00, wr_data=0x11, frame_err=0.
- Write addr 9 code 0x21, then read frame 0x8900 -> miso shifts 0x21 MSB-first on bits 8..15; miso_oe=1 only during that frame. With the macro undefined, miso shifts 0x00.
- Write to addr 10 (frame 0x0A55) -> no we pulse; a following read of addr 10 returns 0x00.
- cs_n raised after 11 bits of frame 0x0533 -> frame_err pulses once, no we, busy returns to 0, and the next full frame 0x0533 writes normally.
- 20 sclk cycles in one cs_n window with the first 16 bits = 0x0207 -> one we (addr 2, code 0x07); extra bits ignored.
- Assert rst at bit 12 with cs_n held low -> all outputs 0 and no we; after rst release, no write until cs_n goes high and a new full frame completes.

Source files
------------

// File: rtl/spi_gain_bridge.sv
// SPI mode-0 slave that turns 16-bit host frames into single-cycle gain register writes.
// Define SPI_SHADOW_READBACK_EN to keep a shadow copy of band codes for MISO readback.
module spi_gain_bridge #(
  parameter int NUM_BANDS  = 10,
  parameter int CODE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  we,
  output logic [7:0]            addr,
  output logic [CODE_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int FW = 8 + CODE_WIDTH;
  localparam int AW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam logic [7:0] NB = 8'(NUM_BANDS);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [1:0]            sclk_sq, cs_sq, mosi_sq;
  logic                  sclk_prev_q;
  logic [FW-1:0]         sh_q, sh_d, sh_shift;
  logic [4:0]            cnt_q, cnt_d;
  logic [CODE_WIDTH-1:0] tx_q, tx_d, rd_code;
  logic                  oe_q, oe_d, miso_q, miso_d, ferr_q, ferr_d;
  logic                  sclk_s, cs_s, mosi_s, rise, fall;
  logic [6:0]            look_a, frm_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sq     <= '0;
      cs_sq       <= '0;
      mosi_sq     <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sq     <= {sclk_sq[0], sclk};
      cs_sq       <= {cs_sq[0], cs_n};
      mosi_sq     <= {mosi_sq[0], mosi};
      sclk_prev_q <= sclk_sq[1];
    end
  end

  assign sclk_s   = sclk_sq[1];
  assign cs_s     = cs_sq[1];
  assign mosi_s   = mosi_sq[1];
  assign rise     = sclk_s & ~sclk_prev_q;
  assign fall     = ~sclk_s & sclk_prev_q;
  assign sh_shift = {sh_q[FW-2:0], mosi_s};
  // Header byte as it will stand once the 8th bit lands; used for the read lookup.
  assign look_a   = sh_shift[6:0];
  assign frm_a    = sh_q[FW-2:CODE_WIDTH];

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NB;
  endfunction

`ifdef SPI_SHADOW_READBACK_EN
  logic [CODE_WIDTH-1:0] shadow_q [NUM_BANDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANDS; i++) shadow_q[i] <= '0;
    end else if (we) begin
      shadow_q[frm_a[AW-1:0]] <= sh_q[CODE_WIDTH-1:0];
    end
  end

  assign rd_code = in_range(look_a) ? shadow_q[look_a[AW-1:0]] : '0;
`else
  assign rd_code = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      oe_q    <= 1'b0;
      miso_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      oe_q    <= oe_d;
      miso_q  <= miso_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    oe_d    = oe_q;
    miso_d  = miso_q;
    ferr_d  = 1'b0;
    case (state_q)
      WAIT_IDLE: if (cs_s) state_d = IDLE;
      IDLE: begin
        if (!cs_s) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh_d    = '0;
        end
      end
      SHIFT: begin
        // Deselect wins over any coincident sclk edge: a short frame never commits.
        if (cs_s) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
        end else if (rise) begin
          sh_d  = sh_shift;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7 && sh_shift[7]) begin
            tx_d = rd_code;
            oe_d = 1'b1;
          end
          if (cnt_q == 5'(FW - 1)) state_d = COMMIT;
        end else if (fall && oe_q) begin
          miso_d = tx_q[CODE_WIDTH-1];
          tx_d   = tx_q << 1;
        end
      end
      COMMIT: state_d = DRAIN;
      DRAIN: begin
        if (cs_s) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign we        = (state_q == COMMIT) && !sh_q[FW-1] && in_range(frm_a);
  assign addr      = we ? {1'b0, frm_a} : '0;
  assign wr_data   = we ? sh_q[CODE_WIDTH-1:0] : '0;
  assign busy      = (state_q == SHIFT) || (state_q == COMMIT) || (state_q == DRAIN);
  assign miso      = miso_q;
  assign miso_oe   = oe_q;
  assign frame_err = ferr_q;

endmodule
